mem_lock_arbiter: RTL and testbench

- Responder end of the SIC memory-lock protocol. Collects `mem_rpl` lock requests and `mem_req` access requests from NUM_SIC memory sub-SICs.
- Grants the single data-memory port to one SIC at a time, picking the oldest issue_id.
- Drives a 1-cycle-latency synchronous data RAM. Returns `mem_grant` and `mem_rdata` so that the LW commit and SW write both land in the grant cycle.

---
 rtl/mem_lock_arbiter_pkg.sv | 23 ++
 rtl/mem_lock_arbiter_if.sv | 37 +++
 rtl/mem_lock_arbiter_oldest_req_select.sv | 64 ++++++
 rtl/mem_lock_arbiter.sv | 102 ++++++++++
 tb/tb_mem_lock_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types and helpers for the SIC memory-lock arbiter: FSM state,
// word-address width and the wrap-aware issue_id age compare.
package mem_lock_arbiter_pkg;

    localparam int MEM_WORD_ADDR_W = 30;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // a is older than b when (a - b) mod 2^width has its top bit set.
    function automatic logic id_older(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned width
    );
        logic [31:0] diff;
        diff = (a - b) >> (width - 1);
        return diff[0];
    endfunction

endpackage

// File: rtl/mem_lock_arbiter_if.sv
// Bundle of the per-SIC lock/access signals and the data-RAM port.
// slave = arbiter side, master = requester/RAM side.
interface mem_lock_arbiter_if #(
    parameter int NUM_SIC  = 2,
    parameter int ID_WIDTH = 4
) ();
    import mem_lock_arbiter_pkg::*;

    logic [NUM_SIC-1:0]                      sic_req;
    logic [NUM_SIC-1:0][ID_WIDTH-1:0]        sic_issue_id;
    logic [NUM_SIC-1:0]                      sic_release;
    logic [NUM_SIC-1:0][MEM_WORD_ADDR_W-1:0] sic_addr;
    logic [NUM_SIC-1:0][31:0]                sic_wdata;
    logic [NUM_SIC-1:0]                      sic_wen;
    logic [NUM_SIC-1:0]                      sic_grant;
    logic [31:0]                             sic_rdata;

    logic                                    dmem_ren;
    logic                                    dmem_wen;
    logic [MEM_WORD_ADDR_W-1:0]              dmem_addr;
    logic [31:0]                             dmem_wdata;
    logic [31:0]                             dmem_rdata;

    modport slave (
        input  sic_req, sic_issue_id, sic_release, sic_addr, sic_wdata, sic_wen,
        output sic_grant, sic_rdata,
        output dmem_ren, dmem_wen, dmem_addr, dmem_wdata,
        input  dmem_rdata
    );

    modport master (
        output sic_req, sic_issue_id, sic_release, sic_addr, sic_wdata, sic_wen,
        input  sic_grant, sic_rdata,
        input  dmem_ren, dmem_wen, dmem_addr, dmem_wdata,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_lock_arbiter_oldest_req_select.sv
// Combinational tournament tree picking one requester; oldest issue_id wins
// when MEM_LOCK_ARB_AGE_ORDER_EN is defined, else the lowest index wins.
module oldest_req_select
    import mem_lock_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = 2,
    parameter int ID_WIDTH = 4,
    parameter int IDX_W    = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1
) (
    input  logic [NUM_SIC-1:0]               req_i,
    input  logic [NUM_SIC-1:0][ID_WIDTH-1:0] issue_id_i,
    output logic [IDX_W-1:0]                 sel_o,
    output logic                             any_req_o
);
    localparam int LEVELS = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 0;
    localparam int LEAVES = 1 << LEVELS;
    localparam int NODES  = 2 * LEAVES - 1;

    // Heap layout: node k has children 2k+1 (lower indices) and 2k+2.
    logic             node_vld [NODES];
    logic [IDX_W-1:0] node_idx [NODES];
    logic             take_r;
`ifdef MEM_LOCK_ARB_AGE_ORDER_EN
    logic [ID_WIDTH-1:0] node_id [NODES];
`else
    logic unused_ids;
    assign unused_ids = ^issue_id_i;
`endif

    always_comb begin
        take_r = 1'b0;
        for (int k = 0; k < NODES; k++) begin
            node_vld[k] = 1'b0;
            node_idx[k] = '0;
`ifdef MEM_LOCK_ARB_AGE_ORDER_EN
            node_id[k]  = '0;
`endif
        end
        for (int i = 0; i < NUM_SIC; i++) begin
            node_vld[LEAVES-1+i] = req_i[i];
            node_idx[LEAVES-1+i] = IDX_W'(i);
`ifdef MEM_LOCK_ARB_AGE_ORDER_EN
            node_id[LEAVES-1+i]  = issue_id_i[i];
`endif
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            // Right child only wins when strictly older, so ties go low.
`ifdef MEM_LOCK_ARB_AGE_ORDER_EN
            take_r = node_vld[2*k+2] &&
                     (!node_vld[2*k+1] ||
                      id_older(32'(node_id[2*k+2]), 32'(node_id[2*k+1]), ID_WIDTH));
            node_id[k]  = take_r ? node_id[2*k+2] : node_id[2*k+1];
`else
            take_r = !node_vld[2*k+1];
`endif
            node_vld[k] = node_vld[2*k+1] | node_vld[2*k+2];
            node_idx[k] = take_r ? node_idx[2*k+2] : node_idx[2*k+1];
        end
    end

    assign sel_o     = node_idx[0];
    assign any_req_o = node_vld[0];

endmodule

// File: rtl/mem_lock_arbiter.sv
// Responder end of the SIC memory-lock protocol: one RAM access per lock,
// read issued in IDLE, grant/write in BUSY. Macro: MEM_LOCK_ARB_AGE_ORDER_EN.
module mem_lock_arbiter
    import mem_lock_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = 2,
    parameter int ID_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_lock_arbiter_if.slave arb_if
);
    localparam int IDX_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           owner_q, owner_d;
    logic [IDX_W-1:0]           sel;
    logic                       any_req;

    logic [NUM_SIC-1:0]         grant_c;
    logic [31:0]                rdata_c;
    logic                       ren_c;
    logic                       wen_c;
    logic [MEM_WORD_ADDR_W-1:0] addr_c;
    logic [31:0]                wdata_c;

    oldest_req_select #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_WIDTH),
        .IDX_W    (IDX_W)
    ) u_select (
        .req_i      (arb_if.sic_req),
        .issue_id_i (arb_if.sic_issue_id),
        .sel_o      (sel),
        .any_req_o  (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_c = '0;
        rdata_c = '0;
        ren_c   = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    ren_c   = 1'b1;
                    addr_c  = arb_if.sic_addr[sel];
                    owner_d = sel;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                addr_c  = arb_if.sic_addr[owner_q];
                rdata_c = arb_if.dmem_rdata;
                // A dropped req means the SIC aborted: the read is simply discarded.
                if (arb_if.sic_req[owner_q]) begin
                    grant_c[owner_q] = 1'b1;
                    wen_c            = arb_if.sic_wen[owner_q];
                    wdata_c          = arb_if.sic_wdata[owner_q];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are combinational off the inputs, so hold them quiet in reset.
        if (!rst_n) begin
            grant_c = '0;
            rdata_c = '0;
            ren_c   = 1'b0;
            wen_c   = 1'b0;
            addr_c  = '0;
            wdata_c = '0;
        end
    end

    assign arb_if.sic_grant  = grant_c;
    assign arb_if.sic_rdata  = rdata_c;
    assign arb_if.dmem_ren   = ren_c;
    assign arb_if.dmem_wen   = wen_c;
    assign arb_if.dmem_addr  = addr_c;
    assign arb_if.dmem_wdata = wdata_c;

    release_with_grant_a: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == BUSY && arb_if.sic_req[owner_q]) |-> arb_if.sic_release[owner_q]
    );

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed bench for mem_lock_arbiter with a behavioural 1-cycle RAM.
// Ordering expectations follow MEM_LOCK_ARB_AGE_ORDER_EN.
module tb_mem_lock_arbiter;
    localparam int NUM_SIC  = 2;
    localparam int ID_WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   wen_count = 0;

    always #5 clk = ~clk;

    mem_lock_arbiter_if #(.NUM_SIC(NUM_SIC), .ID_WIDTH(ID_WIDTH)) bus ();

    mem_lock_arbiter #(.NUM_SIC(NUM_SIC), .ID_WIDTH(ID_WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    // Behavioural RAM with a preload port so only this block writes the array.
    logic [31:0] ram [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (bus.dmem_wen === 1'b1) ram[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
        if (bus.dmem_ren === 1'b1) bus.dmem_rdata <= ram[bus.dmem_addr[7:0]];
        if (bus.dmem_wen === 1'b1) wen_count <= wen_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.sic_req      = '0;
        bus.sic_issue_id = '0;
        bus.sic_release  = '0;
        bus.sic_addr     = '0;
        bus.sic_wdata    = '0;
        bus.sic_wen      = '0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        bus.sic_req = 2'b01;
        bus.sic_addr[0] = 30'h7;
        tick(); tick();
        total++; if (bus.sic_grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got=%b want=00", bus.sic_grant); end
        total++; if (bus.dmem_ren !== 1'b0) begin bad++; $display("FAIL reset_ren: got=%b want=0", bus.dmem_ren); end
        total++; if (bus.dmem_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got=%b want=0", bus.dmem_wen); end
        total++; if (bus.dmem_addr !== 30'h0) begin bad++; $display("FAIL reset_addr: got=%h want=0", bus.dmem_addr); end
        total++; if (bus.sic_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got=%h want=0", bus.sic_rdata); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        $display("[reset] outputs quiet while rst_n low");
    endtask

    task automatic test_lw_single();
        bus.sic_req[0] = 1'b1; bus.sic_issue_id[0] = 4'd3; bus.sic_addr[0] = 30'h10;
        #1;
        total++; if (bus.dmem_ren !== 1'b1) begin bad++; $display("FAIL lw_ren: got=%b want=1", bus.dmem_ren); end
        total++; if (bus.dmem_addr !== 30'h10) begin bad++; $display("FAIL lw_addr: got=%h want=10", bus.dmem_addr); end
        total++; if (bus.sic_grant !== 2'b00) begin bad++; $display("FAIL lw_nogrant_idle: got=%b want=00", bus.sic_grant); end
        tick();
        bus.sic_release[0] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== 2'b01) begin bad++; $display("FAIL lw_grant: got=%b want=01", bus.sic_grant); end
        total++; if (bus.sic_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got=%h want=deadbeef", bus.sic_rdata); end
        total++; if (bus.dmem_ren !== 1'b0) begin bad++; $display("FAIL lw_ren_busy: got=%b want=0", bus.dmem_ren); end
        total++; if (bus.dmem_wen !== 1'b0) begin bad++; $display("FAIL lw_wen: got=%b want=0", bus.dmem_wen); end
        tick();
        // A new request at T+2 must be arbitrated at once, proving the FSM is back in IDLE.
        bus.sic_release[0] = 1'b0;
        #1;
        total++; if (bus.dmem_ren !== 1'b1) begin bad++; $display("FAIL lw_idle_t2: ren got=%b want=1", bus.dmem_ren); end
        tick();
        bus.sic_release[0] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== 2'b01) begin bad++; $display("FAIL lw_regrant: got=%b want=01", bus.sic_grant); end
        tick();
        clear_inputs();
        $display("[lw] sic0 addr=10 read deadbeef");
    endtask

    task automatic test_sw_single();
        int wc;
        wc = wen_count;
        bus.sic_req[1] = 1'b1; bus.sic_addr[1] = 30'h20;
        bus.sic_wdata[1] = 32'h12345678; bus.sic_wen[1] = 1'b1;
        #1;
        total++; if (bus.dmem_wen !== 1'b0) begin bad++; $display("FAIL sw_wen_idle: got=%b want=0", bus.dmem_wen); end
        tick();
        bus.sic_release[1] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== 2'b10) begin bad++; $display("FAIL sw_grant: got=%b want=10", bus.sic_grant); end
        total++; if (bus.dmem_wen !== 1'b1) begin bad++; $display("FAIL sw_wen: got=%b want=1", bus.dmem_wen); end
        total++; if (bus.dmem_wdata !== 32'h12345678) begin bad++; $display("FAIL sw_wdata: got=%h want=12345678", bus.dmem_wdata); end
        total++; if (bus.dmem_addr !== 30'h20) begin bad++; $display("FAIL sw_addr: got=%h want=20", bus.dmem_addr); end
        tick();
        clear_inputs();
        #1;
        total++; if (wen_count - wc !== 1) begin bad++; $display("FAIL sw_wen_pulses: got=%0d want=1", wen_count - wc); end
        total++; if (ram[8'h20] !== 32'h12345678) begin bad++; $display("FAIL sw_ram: got=%h want=12345678", ram[8'h20]); end
        $display("[sw] sic1 addr=20 wrote 12345678");
    endtask

    task automatic test_ordering(input logic [3:0] id0, input logic [3:0] id1, input int first, input string name);
        int other;
        logic [1:0] g_first, g_other;
        logic [29:0] a_first, a_other;
        other   = 1 - first;
        g_first = (first == 0) ? 2'b01 : 2'b10;
        g_other = (first == 0) ? 2'b10 : 2'b01;
        a_first = (first == 0) ? 30'h60 : 30'h70;
        a_other = (first == 0) ? 30'h70 : 30'h60;
        bus.sic_req = 2'b11;
        bus.sic_issue_id[0] = id0; bus.sic_issue_id[1] = id1;
        bus.sic_addr[0] = 30'h60; bus.sic_addr[1] = 30'h70;
        #1;
        total++; if (bus.dmem_addr !== a_first) begin bad++; $display("FAIL order_addr1 %s: got=%h want=%h", name, bus.dmem_addr, a_first); end
        tick();
        bus.sic_release[first] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== g_first) begin bad++; $display("FAIL order_grant1 %s: got=%b want=%b", name, bus.sic_grant, g_first); end
        tick();
        bus.sic_req[first] = 1'b0; bus.sic_release[first] = 1'b0;
        #1;
        total++; if (bus.dmem_addr !== a_other || bus.dmem_ren !== 1'b1) begin bad++; $display("FAIL order_addr2 %s: got=%h ren=%b want=%h ren=1", name, bus.dmem_addr, bus.dmem_ren, a_other); end
        tick();
        bus.sic_release[other] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== g_other) begin bad++; $display("FAIL order_grant2 %s: got=%b want=%b", name, bus.sic_grant, g_other); end
        tick();
        clear_inputs();
        $display("[order] %s ids %0d/%0d first=sic%0d", name, id0, id1, first);
    endtask

    task automatic test_abort();
        int wc;
        wc = wen_count;
        bus.sic_req = 2'b11;
        bus.sic_issue_id[0] = 4'd1; bus.sic_issue_id[1] = 4'd2;
        bus.sic_addr[0] = 30'h30; bus.sic_addr[1] = 30'h40;
        bus.sic_wen[0] = 1'b1; bus.sic_wdata[0] = 32'h00000BAD;
        #1;
        total++; if (bus.dmem_addr !== 30'h30) begin bad++; $display("FAIL abort_addr0: got=%h want=30", bus.dmem_addr); end
        tick();
        bus.sic_req[0] = 1'b0;
        #1;
        total++; if (bus.sic_grant !== 2'b00) begin bad++; $display("FAIL abort_nogrant: got=%b want=00", bus.sic_grant); end
        total++; if (bus.dmem_wen !== 1'b0) begin bad++; $display("FAIL abort_wen: got=%b want=0", bus.dmem_wen); end
        tick();
        #1;
        total++; if (bus.dmem_ren !== 1'b1 || bus.dmem_addr !== 30'h40) begin bad++; $display("FAIL abort_rearb: ren=%b addr=%h want ren=1 addr=40", bus.dmem_ren, bus.dmem_addr); end
        tick();
        bus.sic_release[1] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== 2'b10) begin bad++; $display("FAIL abort_grant1: got=%b want=10", bus.sic_grant); end
        total++; if (bus.sic_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_rdata1: got=%h want=cafef00d", bus.sic_rdata); end
        tick();
        clear_inputs();
        #1;
        total++; if (wen_count !== wc) begin bad++; $display("FAIL abort_wen_pulses: got=%0d want=%0d", wen_count, wc); end
        $display("[abort] sic0 aborted, sic1 granted at T+3");
    endtask

    task automatic test_reset_mid_busy();
        int wc;
        wc = wen_count;
        bus.sic_req[0] = 1'b1; bus.sic_addr[0] = 30'h50;
        bus.sic_wen[0] = 1'b1; bus.sic_wdata[0] = 32'hA5A5A5A5;
        tick();
        bus.sic_release[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.sic_grant !== 2'b00) begin bad++; $display("FAIL rstbusy_grant: got=%b want=00", bus.sic_grant); end
        total++; if (bus.dmem_wen !== 1'b0) begin bad++; $display("FAIL rstbusy_wen: got=%b want=0", bus.dmem_wen); end
        total++; if (bus.sic_rdata !== 32'h0 || bus.dmem_addr !== 30'h0 || bus.dmem_ren !== 1'b0) begin bad++; $display("FAIL rstbusy_outs: rdata=%h addr=%h ren=%b want 0", bus.sic_rdata, bus.dmem_addr, bus.dmem_ren); end
        tick(); tick();
        rst_n = 1'b1;
        bus.sic_release[0] = 1'b0; bus.sic_wen[0] = 1'b0;
        #1;
        total++; if (bus.dmem_ren !== 1'b1 || bus.dmem_addr !== 30'h50) begin bad++; $display("FAIL rstbusy_fresh_ren: ren=%b addr=%h want ren=1 addr=50", bus.dmem_ren, bus.dmem_addr); end
        tick();
        bus.sic_release[0] = 1'b1;
        #1;
        total++; if (bus.sic_grant !== 2'b01) begin bad++; $display("FAIL rstbusy_fresh_grant: got=%b want=01", bus.sic_grant); end
        total++; if (bus.sic_rdata !== 32'h11111111) begin bad++; $display("FAIL rstbusy_ram_intact: got=%h want=11111111", bus.sic_rdata); end
        tick();
        clear_inputs();
        #1;
        total++; if (wen_count !== wc) begin bad++; $display("FAIL rstbusy_wen_pulses: got=%0d want=%0d", wen_count, wc); end
        $display("[rst_busy] reset during BUSY suppressed write; fresh request granted");
    endtask

    initial begin
        test_reset();
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h40, 32'hCAFEF00D);
        preload(8'h50, 32'h11111111);
        test_lw_single();
        test_sw_single();
`ifdef MEM_LOCK_ARB_AGE_ORDER_EN
        test_ordering(4'd5, 4'd2, 1, "ids5v2");
        test_ordering(4'd1, 4'd15, 1, "wrap1v15");
        test_ordering(4'd4, 4'd4, 0, "tie");
`else
        test_ordering(4'd7, 4'd2, 0, "fixed7v2");
        test_ordering(4'd5, 4'd2, 0, "fixed5v2");
        test_ordering(4'd1, 4'd15, 0, "fixed1v15");
`endif
        test_abort();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
